ram512_stream_reader: RTL and testbench
=======================================

Name: ram512_stream_reader

Overview:
- Read-side sequencer for the 512x16 simple-dual-port coefficient/sample RAMs (port B).
- On a start command it reads LENGTH words beginning at BASE_ADDR, wrapping modulo 512.
- It streams the words out on a valid/ready interface with full backpressure and no lost or duplicated words.
- It sits between the RAM read port and the beamforming/FIR datapath that consumes the coefficients.

Parameters:
- ADDR_W, 9, RAM address width; depth = 2**ADDR_W = 512.
- DATA_W, 16, RAM word width, two's-complement data passed through unmodified.

Ports:
- clk  in  1  single system clock; also drives RAM clkb.
- reset  in  1  asynchronous, active-high; also drives RAM resetb.
- start  in  1  one-cycle request; accepted only in IDLE.
- base_addr  in  ADDR_W  first RAM address, sampled at accepted start.
- length  in  ADDR_W+1  number of words, sampled at accepted start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- ram_ceb  out  1  RAM port-B clock enable; one read is issued per cycle it is high.
- ram_oce  out  1  tied 1.
- ram_adb  out  ADDR_W  RAM read address.
- ram_dout  in  DATA_W  RAM read data, valid 1 cycle after the issuing ram_ceb cycle.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset values: busy=0, done=0, ram_ceb=0, ram_adb=0, m_valid=0, m_last=0, m_data=0; FSM in IDLE; FIFO empty.
- Reset mid-transfer aborts the transfer. No done pulse is generated. The in-flight RAM read is discarded.
- FSM states:
  - IDLE: start=1 latches base_addr and the effective length, then goes to ISSUE. If start=1 and length=0, go to DONE instead; no words are emitted.
  - ISSUE: issue reads while remaining>0 and credit is available. When the last read is issued, go to DRAIN.
  - DRAIN: wait until the output FIFO is empty and the last word has been accepted, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1 in this cycle, then IDLE.
- start is ignored (no effect, no error) while not in IDLE.
- Effective length: length>512 is clipped to 512, so one full pass of the RAM.
- Addressing:
  - The read address counter is ADDR_W bits, starts at base_addr and increments per issued read.
  - It wraps naturally (511 -> 0).
  - ram_adb holds its last value when ram_ceb=0.
- RAM read latency:
  - A read issued at edge k (ram_ceb=1, ram_adb=A) returns RAM[A] on ram_dout after edge k.
  - The bench samples it at edge k+1.
  - A 1-bit pipe flag tracks the in-flight read. Returning data is written into the output FIFO at edge k+1 unconditionally.
- Output FIFO:
  - 2 entries, first-word fall-through.
  - m_valid = FIFO non-empty; head drives m_data and m_last.
  - A word is accepted on m_valid & m_ready.
- Credit rule:
  - Issue a read only if (fifo_count + in_flight + pop_this_cycle_adjusted) < 2.
  - Equivalently, issue when fifo_count + in_flight <= 1, counting a same-cycle pop as freeing one slot.
  - The FIFO never overflows; an overflow is an assertion failure.
- Throughput: with m_ready held 1, one word per cycle sustained after 1 cycle of RAM latency.
  - First m_valid appears 2 cycles after the cycle start is accepted: ISSUE entry, read, data.
- m_last travels with the word and is tagged at issue time when remaining==1.
- Simultaneous push and pop on the FIFO, including at count 1 or 2, are legal. Occupancy is unchanged.
- m_data is stable while m_valid=1 and m_ready=0 (AXI-stream rule).
- No arithmetic on the data path; ram_dout is passed through bit-exact.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, ISSUE, DRAIN, DONE);
  - RAM_DEPTH=512;
  - RAM_ADDR_W=9;
  - RAM_DATA_W=16;
  - READ_LATENCY=1.
- One natural sub-module: ram512_out_fifo, the 2-entry FWFT FIFO with DATA_W+1 bits carrying data and last.

Test Plan:
- Full pass, production coefficient image loaded, base=0, length=512, m_ready=1:
  - expect 512 beats with beat0=16'hFFEB, beat1=16'hFF8D, beat3=16'h00A9, beat511=16'h00D1;
  - m_last only on beat511;
  - done 1 cycle after the last beat;
  - total cycles from start to done = 514 ±1, fixed per implementation.
- Wrap-around, base=510, length=4:
  - addresses issued 510, 511, 0, 1;
  - data RAM[510], RAM[511]=16'h00D1, RAM[0]=16'hFFEB, RAM[1]=16'hFF8D.
- Backpressure, base=0, length=8, m_ready toggled by a pseudo-random pattern including a 20-cycle stall:
  - exactly 8 in-order beats, no drops or duplicates;
  - m_data is stable during the stall;
  - ram_ceb never causes the FIFO to exceed 2 entries.
- Boundaries:
  - length=0 -> no m_valid, done pulses once, busy high ≤2 cycles;
  - length=600 -> exactly 512 beats;
  - start asserted again while busy -> ignored, beat count unchanged.
- Reset mid-transfer:
  - assert reset at beat 5 of a 64-word transfer;
  - all outputs return to reset values asynchronously, no done pulse;
  - a subsequent start with base=3, length=2 yields RAM[3]=16'h00A9 then RAM[4] with m_last on the second beat.

Source files
------------

// File: rtl/ram512_stream_reader_pkg.sv
// Shared types and constants for the 512x16 RAM port-B stream reader.
package ram512_stream_reader_pkg;

    localparam int RAM_DEPTH    = 512;
    localparam int RAM_ADDR_W   = 9;
    localparam int RAM_DATA_W   = 16;
    localparam int READ_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

endpackage

// File: rtl/ram512_out_fifo.sv
// Two-entry first-word-fall-through FIFO; the head is visible whenever count is non-zero.
module ram512_out_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Upstream credit must keep a push from landing on a full FIFO unless a pop frees a slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count == 2'd2));

endmodule

// File: rtl/ram512_stream_reader.sv
// Reads LENGTH words from RAM port B starting at BASE_ADDR (mod 512) and
// streams them out over valid/ready with credit-based flow control.
module ram512_stream_reader
    import ram512_stream_reader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_ceb,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_adb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(1 << ADDR_W);

    rd_state_t         state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   eff_len;
    logic              in_flight;
    logic              last_flight;
    logic              issue;
    logic              credit_ok;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;

    assign eff_len = (length > MAX_LEN) ? MAX_LEN : length;
    assign pop     = m_valid & m_ready;
    // A pop in this cycle frees the slot the new read will need two edges later.
    assign credit_ok = ({1'b0, fifo_count} + {2'b0, in_flight}) <= (3'd1 + {2'b0, pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = (eff_len == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (remaining != '0 && credit_ok) begin
                    issue = 1'b1;
                    if (remaining == (ADDR_W + 1)'(1)) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!in_flight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                    state_n = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            remaining   <= '0;
            in_flight   <= 1'b0;
            last_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (state == ST_IDLE && start) begin
                addr      <= base_addr;
                remaining <= eff_len;
            end else if (issue) begin
                addr        <= addr + 1'b1;
                remaining   <= remaining - 1'b1;
                last_flight <= (remaining == (ADDR_W + 1)'(1));
            end
        end
    end

    ram512_out_fifo #(.WIDTH(DATA_W + 1)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data ({last_flight, ram_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign ram_ceb = issue;
    assign ram_oce = 1'b1;
    assign ram_adb = addr;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_head[DATA_W-1:0];
    assign m_last  = fifo_head[DATA_W];

endmodule

// File: tb/tb_ram512_stream_reader.sv
// Directed bench for ram512_stream_reader with a behavioural 1-cycle-latency RAM.
module tb_ram512_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  length;
    logic        busy, done, ram_ceb, ram_oce;
    logic [8:0]  ram_adb;
    logic [15:0] ram_dout;
    logic [15:0] m_data;
    logic        m_valid, m_ready, m_last;

    always #5 clk = ~clk;

    ram512_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_ceb(ram_ceb), .ram_oce(ram_oce), .ram_adb(ram_adb),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    logic [15:0] mem [512];

    always @(posedge clk) if (ram_ceb) ram_dout <= mem[ram_adb];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Stream monitor
    logic [15:0] beats [$];
    logic        lasts [$];
    int          addrs [$];
    int          done_cnt, busy_cnt, stall_err;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data != prev_data || m_last != prev_last))
                stall_err++;
            if (m_valid && m_ready) begin
                beats.push_back(m_data);
                lasts.push_back(m_last);
            end
            if (ram_ceb) addrs.push_back(int'(ram_adb));
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // mode 0: ready held 1; mode 1: random ready with a 20-cycle stall; mode 2: ready 1 plus a start while busy
    task automatic run_xfer(input int base, input int len, input int mode, output int cyc);
        int seen;
        beats.delete(); lasts.delete(); addrs.delete();
        done_cnt = 0; busy_cnt = 0; stall_err = 0;
        seen = 0;
        m_ready   = 1'b1;
        base_addr = 9'(base);
        length    = 10'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
            @(posedge clk); #1;
            cyc++;
            if (mode == 1) m_ready = (cyc >= 4 && cyc < 24) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (mode == 2) begin
                start     = (cyc == 3);
                base_addr = 9'd200;
                length    = 10'd5;
            end
        end
        chk("done_seen", seen, 1);
        start   = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base, input int nbeats);
        int derr, lerr, aerr;
        derr = 0; lerr = 0; aerr = 0;
        chk({tag, "_beats"}, beats.size(), nbeats);
        chk({tag, "_issues"}, addrs.size(), nbeats);
        foreach (beats[i]) begin
            if (beats[i] != mem[(base + i) % 512]) derr++;
            if (lasts[i] != (i == beats.size() - 1)) lerr++;
        end
        foreach (addrs[i]) if (addrs[i] != (base + i) % 512) aerr++;
        chk({tag, "_data_err"}, derr, 0);
        chk({tag, "_last_err"}, lerr, 0);
        chk({tag, "_addr_err"}, aerr, 0);
        chk({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    typedef struct {
        string name;
        int    base;
        int    len;
        int    exp_beats;
        int    exp_cyc;
        int    exp_first;
        int    exp_final;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc;
        vecs[0] = '{"full",   0,   512, 512, 514, 32'hFFEB, 32'h00D1};
        vecs[1] = '{"wrap",   510, 4,   4,   6,   -1,       32'h008D};
        vecs[2] = '{"short",  3,   2,   2,   4,   32'h00A9, -1};
        vecs[3] = '{"clip",   0,   600, 512, 514, 32'hFFEB, 32'h00D1};
        vecs[4] = '{"zero",   7,   0,   0,   0,   -1,       -1};
        vecs[5] = '{"single", 100, 1,   1,   3,   -1,       -1};
        vecs[1].exp_final = 32'hFF8D;

        for (int i = 0; i < 512; i++) mem[i] = 16'((i * 37 + 11) ^ (i << 7));
        mem[0]   = 16'hFFEB;
        mem[1]   = 16'hFF8D;
        mem[3]   = 16'h00A9;
        mem[511] = 16'h00D1;

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ceb", ram_ceb, 0);
        chk("rst_adb", ram_adb, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("oce", ram_oce, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            run_xfer(vecs[v].base, vecs[v].len, 0, cyc);
            check_stream(vecs[v].name, vecs[v].base, vecs[v].exp_beats);
            chk({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cyc);
            chk({vecs[v].name, "_busy_cycles"}, busy_cnt, vecs[v].exp_cyc + 1);
            if (vecs[v].exp_first >= 0 && beats.size() > 0)
                chk({vecs[v].name, "_beat0"}, beats[0], vecs[v].exp_first);
            if (vecs[v].exp_final >= 0 && beats.size() > 0)
                chk({vecs[v].name, "_final"}, beats[beats.size() - 1], vecs[v].exp_final);
        end
        if (beats.size() == 0) chk("single_no_beats", 0, 1);

        // Full-pass spot values at beats 1 and 3
        run_xfer(0, 512, 0, cyc);
        if (beats.size() == 512) begin
            chk("full_beat1", beats[1], 16'hFF8D);
            chk("full_beat3", beats[3], 16'h00A9);
        end else chk("full_rerun_beats", beats.size(), 512);

        // Backpressure with a long stall
        run_xfer(0, 8, 1, cyc);
        check_stream("bp", 0, 8);
        chk("bp_stall_err", stall_err, 0);

        // Second start while busy must be ignored
        run_xfer(20, 16, 2, cyc);
        check_stream("restart", 20, 16);
        chk("restart_cycles", cyc, 18);

        // Reset at beat 5 of a 64-word transfer
        beats.delete(); lasts.delete(); addrs.delete(); done_cnt = 0;
        base_addr = 9'd0; length = 10'd64; m_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (beats.size() < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reach_beat5", beats.size() >= 5, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_ceb", ram_ceb, 0);
        chk("mid_adb", ram_adb, 0);
        chk("mid_valid", m_valid, 0);
        chk("mid_last", m_last, 0);
        chk("mid_data", m_data, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_done", done_cnt, 0);
        chk("mid_idle_valid", m_valid, 0);

        run_xfer(3, 2, 0, cyc);
        check_stream("post_rst", 3, 2);
        if (beats.size() == 2) begin
            chk("post_rst_b0", beats[0], 16'h00A9);
            chk("post_rst_b1", beats[1], mem[4]);
            chk("post_rst_last0", lasts[0], 0);
            chk("post_rst_last1", lasts[1], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
